// File: rtl/mmc3_scanline_irq.sv
// MMC3-class scanline IRQ unit: filters PPU A12 into scanline clocks, runs the
// reload/decrement counter, raises the IRQ and exposes its state for save states.
module mmc3_scanline_irq #(
  parameter int unsigned FILT_M2 = 3,
  parameter int unsigned SS_BASE = 10
) (
  input  logic       clk,
  input  logic       map_rst_n,
  input  logic       m2,
  input  logic       ppu_a12,
  input  logic       rev_a,
  input  logic       wr_latch,
  input  logic       wr_reload,
  input  logic       wr_disable,
  input  logic       wr_enable,
  input  logic [7:0] wr_dat,
  input  logic       ss_we,
  input  logic [7:0] ss_addr,
  input  logic [7:0] ss_wdat,
  output logic [7:0] ss_rdat,
  output logic       irq,
  output logic       a12_clk
);

  localparam logic [1:0] FiltCnt = 2'(FILT_M2);
  localparam logic [7:0] SsCnt   = 8'(SS_BASE);
  localparam logic [7:0] SsLat   = 8'(SS_BASE + 1);
  localparam logic [7:0] SsCtl   = 8'(SS_BASE + 2);

  logic [1:0] r_m2_sync;
  logic [1:0] r_a12_sync;
  logic       r_m2_d;
  logic       r_a12_d;
  logic [1:0] r_lowcnt;
  logic       r_a12_clk;
  logic [7:0] r_counter;
  logic [7:0] r_latch;
  logic       r_reload_pend;
  logic       r_irq_en;
  logic       r_irq;

  logic       w_m2_s;
  logic       w_a12_s;
  logic       w_m2_fall;
  logic       w_a12_rise;
  logic       w_ss_hit;
  logic       w_reload_step;
  logic [7:0] w_step_val;
  logic       w_irq_en_eff;
  logic       w_irq_hit;
  logic       w_irq_set;

  assign w_m2_s     = r_m2_sync[1];
  assign w_a12_s    = r_a12_sync[1];
  assign w_m2_fall  = r_m2_d & ~w_m2_s;
  assign w_a12_rise = ~r_a12_d & w_a12_s;

  assign w_ss_hit = ss_we & ((ss_addr == SsCnt) | (ss_addr == SsLat) | (ss_addr == SsCtl));

  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      r_m2_sync  <= 2'b00;
      r_a12_sync <= 2'b00;
      r_m2_d     <= 1'b0;
      r_a12_d    <= 1'b0;
    end else begin
      r_m2_sync  <= {r_m2_sync[0], m2};
      r_a12_sync <= {r_a12_sync[0], ppu_a12};
      r_m2_d     <= w_m2_s;
      r_a12_d    <= w_a12_s;
    end
  end

  // A12 must have been low for FILT_M2 M2 falls for a rise to count.
  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      r_lowcnt  <= 2'd0;
      r_a12_clk <= 1'b0;
    end else begin
      if (w_ss_hit && (ss_addr == SsCtl)) begin
        r_lowcnt <= 2'd0;
      end else if (w_a12_s) begin
        r_lowcnt <= 2'd0;
      end else if (w_m2_fall && (r_lowcnt < FiltCnt)) begin
        r_lowcnt <= r_lowcnt + 2'd1;
      end
      r_a12_clk <= w_a12_rise & (r_lowcnt == FiltCnt);
    end
  end

  assign w_reload_step = (r_counter == 8'd0) | r_reload_pend;
  assign w_step_val    = w_reload_step ? r_latch : (r_counter - 8'd1);
  assign w_irq_en_eff  = r_irq_en | wr_enable;

  always_comb begin
    w_irq_hit = 1'b0;
    if (rev_a) begin
      w_irq_hit = (!r_reload_pend && (r_counter == 8'd1)) ||
                  (r_reload_pend && (r_latch == 8'd0));
    end else begin
      w_irq_hit = (w_step_val == 8'd0);
    end
  end

  // A reload strobe in the step cycle discards the step entirely.
  assign w_irq_set = r_a12_clk & ~wr_reload & w_irq_en_eff & w_irq_hit;

  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      r_counter     <= 8'd0;
      r_latch       <= 8'd0;
      r_reload_pend <= 1'b0;
      r_irq_en      <= 1'b0;
      r_irq         <= 1'b0;
    end else if (w_ss_hit) begin
      if (ss_addr == SsCnt) begin
        r_counter <= ss_wdat;
      end else if (ss_addr == SsLat) begin
        r_latch <= ss_wdat;
      end else begin
        r_reload_pend <= ss_wdat[2];
        r_irq_en      <= ss_wdat[1];
        r_irq         <= ss_wdat[0];
      end
    end else begin
      if (wr_latch) begin
        r_latch <= wr_dat;
      end
      if (wr_reload) begin
        r_reload_pend <= 1'b1;
        r_counter     <= 8'd0;
      end else if (r_a12_clk) begin
        r_counter <= w_step_val;
        if (w_reload_step) begin
          r_reload_pend <= 1'b0;
        end
      end
      if (wr_disable) begin
        r_irq_en <= 1'b0;
        r_irq    <= 1'b0;
      end else begin
        if (wr_enable) begin
          r_irq_en <= 1'b1;
        end
        if (w_irq_set) begin
          r_irq <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    ss_rdat = 8'hFF;
    if (ss_addr == SsCnt) begin
      ss_rdat = r_counter;
    end else if (ss_addr == SsLat) begin
      ss_rdat = r_latch;
    end else if (ss_addr == SsCtl) begin
      ss_rdat = {5'b00000, r_reload_pend, r_irq_en, r_irq};
    end
  end

  assign irq     = r_irq;
  assign a12_clk = r_a12_clk;

endmodule
